// File: rtl/sram_access_seq.sv
// ---------------------------------------------------------------------------
// sram_access_seq
//
// Sequencing master for the SRAM slave wrapper. It turns single-word host
// requests into timed SRAM cycles. Each cycle has a SETUP phase (chip select
// only), a PULSE phase (read or write strobe) and a HOLD phase (chip select
// only). Read data is returned with a one-cycle response pulse. A fill engine
// writes one byte value to every address from 0 to FILL_LAST.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE when no fill is running.
// Once req_valid is raised, the host holds it and the request fields stable
// until the transfer edge. fill_start is sampled under the same req_ready
// condition. If fill_start and req_valid are both high, fill_start wins.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   host request handshake
//   req_write             1 = write, 0 = read
//   req_addr, req_wdata   request address and write data
//   rsp_valid, rsp_rdata  one-cycle read response and the captured data
//   fill_start            start a fill (sampled while req_ready = 1)
//   fill_value            fill byte, captured at start
//   fill_busy, fill_done  fill in progress / one-cycle completion pulse
//   m_*                   active-low strobes, address and data to the wrapper
//   m_readdata            read data from the wrapper
//
// SETUP_CYC, PULSE_CYC and HOLD_CYC must each be at least 1.
// ---------------------------------------------------------------------------
module sram_access_seq #(
    parameter int              ADDR_W    = 17,
    parameter int              DATA_W    = 8,
    parameter int              SETUP_CYC = 1,
    parameter int              PULSE_CYC = 2,
    parameter int              HOLD_CYC  = 1,
    parameter longint unsigned FILL_LAST = (64'd1 << ADDR_W) - 64'd1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              m_chipselect_n,
    output logic              m_byteenable_n,
    output logic              m_write_n,
    output logic              m_read_n,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int                CNT_W    = 16;
    localparam logic [CNT_W-1:0]  SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W-1:0] FILL_END = ADDR_W'(FILL_LAST);

    // Architectural state. m_address and m_writedata also serve as the
    // latched access address and data. During a fill, m_address is the fill
    // address counter.
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             acc_write, acc_write_n;
    logic             fill_busy_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic             phase_end;

    // Next values of the registered outputs.
    logic              cs_n_d;
    logic              write_n_d;
    logic              read_n_d;
    logic              ready_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              fill_done_d;

    // The phase counter counts down to zero. It is reloaded on each phase entry.
    assign phase_end = (cnt == '0);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc_write   <= 1'b0;
            fill_busy   <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            acc_write   <= acc_write_n;
            fill_busy   <= fill_busy_n;
            m_address   <= addr_n;
            m_writedata <= wdata_n;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        acc_write_n = acc_write;
        fill_busy_n = fill_busy;
        addr_n      = m_address;
        wdata_n     = m_writedata;

        case (state)
            ST_IDLE: begin
                if (req_ready && fill_start) begin
                    // A fill is a run of writes starting at address 0.
                    state_n     = ST_SETUP;
                    cnt_n       = SETUP_LD;
                    acc_write_n = 1'b1;
                    fill_busy_n = 1'b1;
                    addr_n      = '0;
                    wdata_n     = fill_value;
                end else if (req_ready && req_valid) begin
                    state_n     = ST_SETUP;
                    cnt_n       = SETUP_LD;
                    acc_write_n = req_write;
                    addr_n      = req_addr;
                    wdata_n     = req_wdata;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    state_n = ST_PULSE;
                    cnt_n   = PULSE_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                if (phase_end) begin
                    state_n = ST_HOLD;
                    cnt_n   = HOLD_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    if (fill_busy && (m_address != FILL_END)) begin
                        // The next fill word starts with no IDLE gap.
                        state_n = ST_SETUP;
                        cnt_n   = SETUP_LD;
                        addr_n  = m_address + 1'b1;
                    end else begin
                        state_n     = ST_IDLE;
                        fill_busy_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // Outputs are decoded from the next state and then registered. This way
    // each strobe changes on the same edge as the phase it belongs to.
    always_comb begin
        cs_n_d      = (state_n == ST_IDLE);
        write_n_d   = !((state_n == ST_PULSE) && acc_write_n);
        read_n_d    = !((state_n == ST_PULSE) && !acc_write_n);
        ready_d     = (state_n == ST_IDLE) && !fill_busy_n;
        // Read data is captured on the edge that leaves the last PULSE cycle.
        rsp_valid_d = (state == ST_PULSE) && phase_end && !acc_write;
        rsp_rdata_d = rsp_valid_d ? m_readdata : rsp_rdata;
        // fill_done marks the last HOLD cycle of the final fill word.
        // The pulse therefore falls inside the fill_busy window.
        fill_done_d = fill_busy_n && (state_n == ST_HOLD) && (cnt_n == '0)
                      && (addr_n == FILL_END);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_chipselect_n <= 1'b1;
            m_byteenable_n <= 1'b1;
            m_write_n      <= 1'b1;
            m_read_n       <= 1'b1;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            fill_done      <= 1'b0;
        end else begin
            m_chipselect_n <= cs_n_d;
            m_byteenable_n <= cs_n_d;
            m_write_n      <= write_n_d;
            m_read_n       <= read_n_d;
            req_ready      <= ready_d;
            rsp_valid      <= rsp_valid_d;
            rsp_rdata      <= rsp_rdata_d;
            fill_done      <= fill_done_d;
        end
    end

endmodule

// File: tb/tb_sram_access_seq.sv
// ---------------------------------------------------------------------------
// tb_sram_access_seq
//
// Directed bench for sram_access_seq with SETUP/PULSE/HOLD = 1/2/1 and
// FILL_LAST = 3. Inputs are driven 1 time unit after the rising edge, and
// outputs are sampled on the falling edge. Single host accesses come from a
// table of records. Fill, fill/request collision and reset during PULSE use
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_sram_access_seq;
    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 8;
    localparam int FILL_LAST = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              fill_start;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;
    logic              m_chipselect_n;
    logic              m_byteenable_n;
    logic              m_write_n;
    logic              m_read_n;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;      // what the memory returns
        logic [DATA_W-1:0] exp_rdata;  // rsp_rdata expected once HOLD is reached
    } vec_t;

    vec_t vecs [7];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    sram_access_seq #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SETUP_CYC(1),
        .PULSE_CYC(2),
        .HOLD_CYC (1),
        .FILL_LAST(FILL_LAST)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .fill_start    (fill_start),
        .fill_value    (fill_value),
        .fill_busy     (fill_busy),
        .fill_done     (fill_done),
        .m_chipselect_n(m_chipselect_n),
        .m_byteenable_n(m_byteenable_n),
        .m_write_n     (m_write_n),
        .m_read_n      (m_read_n),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata)
    );

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Checks the five cycles after a handshake edge. The memory returns rdata
    // only from the middle of the last PULSE cycle to the middle of HOLD.
    // A capture on any other edge therefore sees the inverted value.
    task automatic check_access(input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                                input logic [DATA_W-1:0] exp_rdata);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("cs_n", 32'(m_chipselect_n), 32'((c <= 4) ? 0 : 1));
            chk("be_n", 32'(m_byteenable_n), 32'((c <= 4) ? 0 : 1));
            chk("write_n", 32'(m_write_n), 32'((wr && (c == 2 || c == 3)) ? 0 : 1));
            chk("read_n", 32'(m_read_n), 32'((!wr && (c == 2 || c == 3)) ? 0 : 1));
            chk("rsp_valid", 32'(rsp_valid), 32'(!wr && c == 4));
            chk("req_ready", 32'(req_ready), 32'(c == 5));
            if (c <= 4) chk("address", 32'(m_address), 32'(addr));
            if (wr && c <= 4) chk("writedata", 32'(m_writedata), 32'(wdata));
            if (c >= 4) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            if (c == 3) m_readdata = rdata;
            if (c == 4) m_readdata = ~rdata;
        end
    endtask

    // Waits (bounded) for req_ready at a falling edge.
    task automatic wait_ready(input string name, output logic ok);
        int waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        ok = req_ready;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: req_ready got 0, expected 1 within 20 cycles", name);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_access(input vec_t v);
        logic ok;
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        m_readdata = ~v.rdata;
        wait_ready("access_ready", ok);
        if (ok) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_wdata = ~v.wdata;
            req_addr  = ~v.addr;
            check_access(v.wr, v.addr, v.wdata, v.rdata, v.exp_rdata);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    // Runs a 4-word fill. If with_req is set, a read of 0x10 is offered in
    // the same cycle as fill_start. That read must wait until the fill is done.
    task automatic run_fill(input logic [DATA_W-1:0] value, input logic with_req,
                            input logic [DATA_W-1:0] rd);
        logic ok;
        req_valid  = with_req;
        req_write  = 1'b0;
        req_addr   = 17'h00010;
        req_wdata  = 8'h00;
        m_readdata = ~rd;
        fill_value = value;
        fill_start = 1'b1;
        wait_ready("fill_ready", ok);
        if (!ok) begin
            fill_start = 1'b0;
            req_valid  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        fill_value = ~value;
        for (int c = 1; c <= 16; c++) begin
            int p;
            @(negedge clk);
            p = (c - 1) % 4;
            chk("fill_busy", 32'(fill_busy), 32'd1);
            chk("fill_req_ready", 32'(req_ready), 32'd0);
            chk("fill_cs_n", 32'(m_chipselect_n), 32'd0);
            chk("fill_write_n", 32'(m_write_n), 32'((p == 1 || p == 2) ? 0 : 1));
            chk("fill_read_n", 32'(m_read_n), 32'd1);
            chk("fill_address", 32'(m_address), 32'((c - 1) / 4));
            chk("fill_writedata", 32'(m_writedata), 32'(value));
            chk("fill_done", 32'(fill_done), 32'(c == 16));
            chk("fill_rsp_valid", 32'(rsp_valid), 32'd0);
            // A start request while busy must be ignored.
            if (c == 6) fill_start = 1'b1;
            if (c == 7) fill_start = 1'b0;
        end
        @(negedge clk);
        chk("fill_end_busy", 32'(fill_busy), 32'd0);
        chk("fill_end_done", 32'(fill_done), 32'd0);
        chk("fill_end_ready", 32'(req_ready), 32'd1);
        chk("fill_end_cs_n", 32'(m_chipselect_n), 32'd1);
        if (with_req) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            check_access(1'b0, 17'h00010, 8'h00, rd, rd);
        end
        req_valid = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{1'b1, 17'h00123, 8'hA5, 8'h11, 8'h00};
        vecs[1] = '{1'b0, 17'h00123, 8'h00, 8'h5A, 8'h5A};
        vecs[2] = '{1'b1, 17'h1FFFF, 8'hFF, 8'h22, 8'h5A};
        vecs[3] = '{1'b0, 17'h1FFFF, 8'h00, 8'hC3, 8'hC3};
        vecs[4] = '{1'b0, 17'h00000, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 17'h0AAAA, 8'h3C, 8'h77, 8'h00};
        vecs[6] = '{1'b0, 17'h10001, 8'h00, 8'h96, 8'h96};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        fill_start = 1'b0;
        fill_value = '0;
        m_readdata = 8'hEE;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", 32'(m_chipselect_n), 32'd1);
        chk("rst_be_n", 32'(m_byteenable_n), 32'd1);
        chk("rst_write_n", 32'(m_write_n), 32'd1);
        chk("rst_read_n", 32'(m_read_n), 32'd1);
        chk("rst_address", 32'(m_address), 32'd0);
        chk("rst_writedata", 32'(m_writedata), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", 32'(req_ready), 32'd1);
        chk("rel_cs_n", 32'(m_chipselect_n), 32'd1);

        // Table of single accesses, issued back to back
        for (int i = 0; i < 7; i++) do_access(vecs[i]);

        // Plain fill, then a fill that collides with a read request
        run_fill(8'h00, 1'b0, 8'h00);
        run_fill(8'hE7, 1'b1, 8'h6D);

        // Reset during the second PULSE cycle of a read
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 17'h00456;
        m_readdata = 8'h99;
        begin
            logic ok;
            wait_ready("rstmid_ready", ok);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_pulse1_read_n", 32'(m_read_n), 32'd0);
        @(negedge clk);
        chk("rstmid_pulse2_read_n", 32'(m_read_n), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstmid_cs_n", 32'(m_chipselect_n), 32'd1);
        chk("rstmid_be_n", 32'(m_byteenable_n), 32'd1);
        chk("rstmid_read_n", 32'(m_read_n), 32'd1);
        chk("rstmid_write_n", 32'(m_write_n), 32'd1);
        chk("rstmid_address", 32'(m_address), 32'd0);
        chk("rstmid_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rstmid_rsp_rdata", 32'(rsp_rdata), 32'd0);
        end
        reset_n = 1'b1;
        #1;
        chk("rstmid_rel_ready_before", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rstmid_rel_ready_after", 32'(req_ready), 32'd1);
        chk("rstmid_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_rel_cs_n", 32'(m_chipselect_n), 32'd1);

        // A normal read after the reset
        begin
            vec_t v;
            v = '{1'b0, 17'h00456, 8'h00, 8'h4B, 8'h4B};
            do_access(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
